sag4fun_issue: RTL and testbench
================================

# sag4fun_issue

Command front-end for the sequential SAG4Fun cores (32S/64S). It accepts LDM, SAG and inverse-SAG commands over a valid/ready handshake and issues them one at a time to the core's `ctrl_start` interface. It holds a shadow copy of the loaded mask and applies `msk` masking, which the sequential cores do not do themselves. Results return through a 2-entry response FIFO.

## Interface
- `XLEN`, default 64: data width; 32 or 64, and must match the attached core.
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op` in 2: 00 LDM, 01 SAG (forward), 10 ISAG (inverse), 11 reserved.
- `cmd_msk` in 1: apply mask.
- `cmd_data` in XLEN: mask for LDM, operand otherwise.
- `rsp_valid` out 1: response at FIFO head.
- `rsp_ready` in 1: pop when `rsp_valid && rsp_ready`.
- `rsp_data` out XLEN: result.
- `rsp_err` out 1: command rejected; `rsp_data` is 0.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_inv`, `core_msk`, `core_ldm` out 1 each: core controls.
- `core_din` out XLEN: core `in_data`.
- `core_ready` in 1: core `ctrl_ready`.
- `core_dout` in XLEN: core `out_data`, valid only while `core_ready` is high.
- `mask_loaded` out 1: a mask has been committed since reset.
- `busy` out 1: state is not IDLE.

## Operation
- Registers:
  - Command register: op, msk, data.
  - `mask_reg` (XLEN) and `mask_loaded`.
  - 2-entry FIFO of {err, data} with a 2-bit count.
  - FSM with states IDLE, ISSUE, WAIT.
- `cmd_ready = (state==IDLE) && (count<2)`. On accept, latch the command and go to ISSUE.
- In ISSUE (exactly one cycle), the error check runs first. An error is `op==11`, or `op` in {01,10} with `mask_loaded==0`.
  - Error: push {1, 0}, do not pulse `core_start`, go to IDLE.
  - Otherwise: `core_start=1`, go to WAIT.
  - LDM in ISSUE also sets `mask_reg <= cmd_data` and `mask_loaded <= 1`.
- Core drive, taken from the command register and held constant from ISSUE through WAIT:
  - `core_ldm = (op==00)` and `core_inv = (op==10)`.
  - `core_msk = msk`.
  - `core_din = (op==01 && msk) ? data & mask_reg : data`.
- In WAIT, on `core_ready`:
  - LDM: discard the result and push nothing.
  - SAG: push {0, `core_dout`}.
  - ISAG: push {0, `msk` ? `core_dout & mask_reg` : `core_dout`}.
  - In every case go to IDLE.
- `core_ready` is ignored in IDLE and ISSUE.
- FIFO:
  - Responses stay in order.
  - `rsp_valid = count!=0`; `rsp_data` and `rsp_err` come from the head entry.
  - A push and a pop in the same cycle leave `count` unchanged.
  - Overflow cannot happen: the `count<2` check at accept, plus a single command in flight, guarantees space.
  - When `rsp_valid` is low, `rsp_data` and `rsp_err` are 0.
- LDM with `msk=1`: `msk` is ignored. Reserved op with `msk=1`: still an error.

## Timing
- Reset state:
  - `state=IDLE`, `count=0`, `mask_reg=0`, `mask_loaded=0`.
  - All outputs 0 except `cmd_ready=1`.
- Let L be the core latency from start to `core_ready`: 6 for 64S, 5 for 32S.
- Successful command accepted at edge T:
  - `core_start` is high in cycle T+1.
  - `core_ready` arrives in cycle T+1+L.
  - `rsp_valid` rises in cycle T+2+L.
- Error command accepted at T: `rsp_valid` rises in T+2.
- After a command completes, the next `cmd_ready` is high in the first cycle after the return to IDLE (when the FIFO has room), so back-to-back throughput is one command per L+2 cycles.
- `cmd_ready` stays low while the FIFO is full, even in IDLE.
- Reset asserted mid-operation:
  - The in-flight command is dropped and the FIFO is cleared.
  - `core_start` is not asserted during reset.
  - The core must share the same reset.
- `core_start` is never high for two consecutive cycles.

## Test plan
- **Reset, then SAG before any LDM.** Send op=01, data=0x1234 → `rsp_err=1`, `rsp_data=0`, `rsp_valid` at T+2, `core_start` never pulses.
- **LDM, then masked forward SAG (XLEN=64, 64S core).**
  - LDM with 0x0000_0000_FFFF_0000 → `mask_loaded=1` at T+2, no response.
  - SAG `msk=1`, data 0xDEAD_BEEF_CAFE_F00D → `core_din=0x0000_0000_CAFE_0000` at start, response at T+8 matching the golden model.
- **Inverse with `msk=1`.** Force the core model to return 0xFFFF_FFFF_FFFF_FFFF → `rsp_data=0x0000_0000_FFFF_0000`, `core_inv=1`.
- **Response backpressure.** Hold `rsp_ready=0` and issue 3 SAGs → two responses queued, `cmd_ready=0` after the second completes. Release → responses arrive in order, and the third is then accepted.
- **Reserved op=11.** → error response at T+2. Then a spurious `core_ready` pulse in IDLE → no push.
- **Reset mid-operation.** Assert reset in the WAIT cycle T+4 → `busy=0`, `rsp_valid=0`, `mask_loaded=0` immediately. The next LDM + SAG completes normally.

Source files
------------

// File: rtl/sag4fun_issue.sv
// Command front-end for the sequential SAG4Fun cores: accepts LDM/SAG/ISAG commands,
// issues them one at a time to the core, applies msk masking and queues results.
module sag4fun_issue #(
  parameter int XLEN = 64
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_op_i,
  input  logic            cmd_msk_i,
  input  logic [XLEN-1:0] cmd_data_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_err_o,
  output logic            core_start_o,
  output logic            core_inv_o,
  output logic            core_msk_o,
  output logic            core_ldm_o,
  output logic [XLEN-1:0] core_din_o,
  input  logic            core_ready_i,
  input  logic [XLEN-1:0] core_dout_i,
  output logic            mask_loaded_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [1:0] OP_LDM  = 2'b00;
  localparam logic [1:0] OP_SAG  = 2'b01;
  localparam logic [1:0] OP_ISAG = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic              msk_q;
  logic [XLEN-1:0]   data_q;
  logic [XLEN-1:0]   mask_q;
  logic              mask_loaded_q;

  logic [XLEN-1:0]   fifo_data_q [2];
  logic              fifo_err_q  [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q, count_d;

  logic              accept, push, pop, push_err, active;
  logic [XLEN-1:0]   push_data;

  assign cmd_ready_o = (state_q == IDLE) && (count_q < 2'd2);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign busy_o      = (state_q != IDLE);
  assign active      = busy_o;

  // Core controls come straight from the command register and stay put until IDLE.
  assign core_ldm_o  = active && (op_q == OP_LDM);
  assign core_inv_o  = active && (op_q == OP_ISAG);
  assign core_msk_o  = active && msk_q;
  assign core_din_o  = !active ? '0 :
                       ((op_q == OP_SAG) && msk_q) ? (data_q & mask_q) : data_q;

  assign mask_loaded_o = mask_loaded_q;

  always_comb begin
    state_d      = state_q;
    push         = 1'b0;
    push_err     = 1'b0;
    push_data    = '0;
    core_start_o = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = ISSUE;
      ISSUE: begin
        if ((op_q == OP_RSV) || ((op_q != OP_LDM) && !mask_loaded_q)) begin
          push     = 1'b1;
          push_err = 1'b1;
          state_d  = IDLE;
        end else begin
          core_start_o = 1'b1;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (core_ready_i) begin
          state_d = IDLE;
          if (op_q == OP_SAG) begin
            push      = 1'b1;
            push_data = core_dout_i;
          end else if (op_q == OP_ISAG) begin
            push      = 1'b1;
            push_data = msk_q ? (core_dout_i & mask_q) : core_dout_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      op_q          <= OP_LDM;
      msk_q         <= 1'b0;
      data_q        <= '0;
      mask_q        <= '0;
      mask_loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= cmd_op_i;
        msk_q  <= cmd_msk_i;
        data_q <= cmd_data_i;
      end
      if ((state_q == ISSUE) && (op_q == OP_LDM)) begin
        mask_q        <= data_q;
        mask_loaded_q <= 1'b1;
      end
    end
  end

  // Response FIFO: no overflow guard needed, accept is blocked while it is full.
  assign rsp_valid_o = (count_q != 2'd0);
  assign rsp_data_o  = rsp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_err_o   = rsp_valid_o && fifo_err_q[rd_ptr_q];
  assign pop         = rsp_valid_o && rsp_ready_i;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_err_q[wr_ptr_q]  <= push_err;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_sag4fun_issue.sv
// Directed bench for sag4fun_issue with a behavioural 64S core model (latency 6).
module tb_sag4fun_issue;
  localparam int XLEN = 64;
  localparam int L    = 6;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0, cmd_ready;
  logic [1:0]      cmd_op = 2'b00;
  logic            cmd_msk = 1'b0;
  logic [XLEN-1:0] cmd_data = '0;
  logic            rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [XLEN-1:0] rsp_data;
  logic            core_start, core_inv, core_msk, core_ldm;
  logic [XLEN-1:0] core_din, core_dout;
  logic            core_ready, mask_loaded, busy;

  int n_chk = 0, n_err = 0;
  int start_cnt = 0, dbl_start = 0;

  always #5 clock = ~clock;

  sag4fun_issue #(.XLEN(XLEN)) dut (
    .clock_i(clock), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_msk_i(cmd_msk), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .core_start_o(core_start), .core_inv_o(core_inv), .core_msk_o(core_msk), .core_ldm_o(core_ldm),
    .core_din_o(core_din), .core_ready_i(core_ready), .core_dout_i(core_dout),
    .mask_loaded_o(mask_loaded), .busy_o(busy)
  );

  // Core model: forward SAG gathers mask-one bits to the bottom, mask-zero bits above.
  logic            pend;
  int              cnt;
  logic [XLEN-1:0] mmask, res;
  logic            force_en = 1'b0, spur = 1'b0;
  logic [XLEN-1:0] force_val = '0;

  function automatic logic [XLEN-1:0] sag(input logic [XLEN-1:0] x, input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r = '0;
    int j = 0;
    for (int i = 0; i < XLEN; i++) if (m[i])  begin r[j] = x[i]; j++; end
    for (int i = 0; i < XLEN; i++) if (!m[i]) begin r[j] = x[i]; j++; end
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= 1'b0; cnt <= 0; mmask <= '0; res <= '0;
    end else if (core_start) begin
      pend <= 1'b1; cnt <= L - 1;
      if (core_ldm) begin mmask <= core_din; res <= '0; end
      else if (core_inv) res <= force_en ? force_val : '0;
      else res <= force_en ? force_val : sag(core_din, mmask);
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
  end
  assign core_ready = (pend && cnt == 0) || spur;
  assign core_dout  = res;

  logic start_d = 1'b0;
  always @(posedge clock) begin
    if (core_start) start_cnt++;
    if (core_start && start_d) dbl_start++;
    start_d <= core_start;
  end

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Returns in cycle T+1 of the accepted command.
  task automatic send(input logic [1:0] op, input logic msk, input logic [XLEN-1:0] d);
    int k = 0;
    while (!cmd_ready && k < 50) begin tick(); k++; end
    if (!cmd_ready) check("send_timeout", 1, 0);
    cmd_op = op; cmd_msk = msk; cmd_data = d; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin tick(); k++; end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic pop();
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  int s0;

  initial begin
    tick(2);
    reset = 1'b0;
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mask_loaded", mask_loaded, 0);
    check("rst_core_din", core_din, 0);
    check("rst_core_ldm", core_ldm, 0);

    // SAG before any LDM
    s0 = start_cnt;
    send(2'b01, 1'b0, 64'h1234);
    check("noldm_busy", busy, 1);
    check("noldm_start", core_start, 0);
    tick();
    check("noldm_valid", rsp_valid, 1);
    check("noldm_err", rsp_err, 1);
    check("noldm_data", rsp_data, 0);
    check("noldm_nostart", start_cnt, s0);
    pop();
    check("noldm_popped", rsp_valid, 0);

    // LDM then masked SAG
    send(2'b00, 1'b1, 64'h0000_0000_FFFF_0000);
    check("ldm_start", core_start, 1);
    check("ldm_ctl", core_ldm, 1);
    tick();
    check("ldm_loaded", mask_loaded, 1);
    check("ldm_nostart2", core_start, 0);
    wait_idle();
    tick();
    check("ldm_norsp", rsp_valid, 0);

    send(2'b01, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
    check("sag_start", core_start, 1);
    check("sag_din", core_din, 64'h0000_0000_CAFE_0000);
    check("sag_msk", core_msk, 1);
    check("sag_inv", core_inv, 0);
    tick(L);
    check("sag_ready_T7", core_ready, 1);
    check("sag_valid_T7", rsp_valid, 0);
    tick();
    check("sag_valid_T8", rsp_valid, 1);
    check("sag_err", rsp_err, 0);
    check("sag_data", rsp_data, 64'h0000_0000_0000_CAFE);
    pop();

    // Inverse with msk, forced core output
    force_en = 1'b1; force_val = '1;
    send(2'b10, 1'b1, 64'h1111);
    check("isag_inv", core_inv, 1);
    check("isag_din", core_din, 64'h1111);
    tick(L + 1);
    check("isag_valid", rsp_valid, 1);
    check("isag_data", rsp_data, 64'h0000_0000_FFFF_0000);
    pop();
    force_en = 1'b0;

    // Backpressure: two queued, third held off until a slot frees
    send(2'b01, 1'b0, 64'h0000_0000_0003_0000);
    wait_idle();
    send(2'b01, 1'b0, 64'h0000_0000_0005_0000);
    wait_idle();
    tick();
    check("bp_full_ready", cmd_ready, 0);
    cmd_op = 2'b01; cmd_msk = 1'b0; cmd_data = 64'h0000_0000_0007_0000; cmd_valid = 1'b1;
    tick(3);
    check("bp_held_busy", busy, 0);
    check("bp_head0", rsp_data, 64'h3);
    rsp_ready = 1'b1;
    tick();
    check("bp_head1", rsp_data, 64'h5);
    check("bp_ready_room", cmd_ready, 1);
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    check("bp_third_start", core_start, 1);
    check("bp_empty", rsp_valid, 0);
    wait_idle();
    tick();
    check("bp_third_data", rsp_data, 64'h7);
    pop();

    // Reserved op, then spurious core_ready in IDLE
    s0 = start_cnt;
    send(2'b11, 1'b1, 64'hABCD);
    check("rsv_nostart", core_start, 0);
    tick();
    check("rsv_valid", rsp_valid, 1);
    check("rsv_err", rsp_err, 1);
    pop();
    spur = 1'b1; tick(); spur = 1'b0; tick();
    check("spur_norsp", rsp_valid, 0);
    check("spur_idle", busy, 0);
    check("rsv_starts", start_cnt, s0);

    // Reset during WAIT
    send(2'b01, 1'b0, 64'h0000_0000_0001_0000);
    tick(3);
    reset = 1'b1; #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_loaded", mask_loaded, 0);
    check("mid_rst_start", core_start, 0);
    tick();
    reset = 1'b0;
    tick();
    send(2'b00, 1'b0, 64'h0000_0000_FFFF_0000);
    wait_idle();
    send(2'b01, 1'b0, 64'h0000_0000_00AB_0000);
    check("post_rst_din", core_din, 64'h0000_0000_00AB_0000);
    tick(L + 1);
    check("post_rst_valid", rsp_valid, 1);
    check("post_rst_data", rsp_data, 64'hAB);
    pop();

    check("no_double_start", dbl_start, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
